// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: latches PC into MAR, requests a memory read and
// captures the word into MBR. Optional timeout abort via FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic [7:0]  pc_in,
    output logic [7:0]  mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mbr_out,
    output logic [7:0]  ir_opcode,
    output logic [7:0]  ir_addr,
    output logic        pc_inc,
    output logic        fetch_done,
    output logic        busy,
    output logic        fetch_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT_CYCLES must be 1..255");
    end

`ifdef FETCH_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
`endif

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // MAR only loads when a fetch is accepted, so pc_in is don't-care afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr <= 8'h00;
            mbr_out  <= 16'h0000;
        end else begin
            if (state == IDLE && fetch_start) mem_addr <= pc_in;
            if (state == REQ && mem_ack)      mbr_out  <= mem_rdata;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt;
    logic       tmo_hit;

    // Counter holds the number of unacknowledged REQ cycles already elapsed,
    // so the last permitted wait cycle is the one where it equals TIMEOUT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        tmo_cnt <= 8'h00;
        else if (state == IDLE && fetch_start)             tmo_cnt <= 8'h00;
        else if (state == REQ && !mem_ack && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign tmo_hit = (tmo_cnt >= TMO_LAST);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fetch_start) state_nxt = REQ;
            REQ: begin
                if (mem_ack) state_nxt = DONE;
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_hit) state_nxt = ERR;
`endif
            end
            DONE: state_nxt = IDLE;
`ifdef FETCH_TIMEOUT_EN
            ERR:  state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req    = (state == REQ);
    assign fetch_done = (state == DONE);
    assign pc_inc     = (state == DONE);
    assign busy       = (state != IDLE);
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = (state == ERR);
`else
    assign fetch_err  = 1'b0;
`endif
    assign ir_opcode  = mbr_out[15:8];
    assign ir_addr    = mbr_out[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; timeout scenario is built only with FETCH_TIMEOUT_EN.
module tb_fetch_unit;

    localparam int TO = 3;
`ifdef FETCH_TIMEOUT_EN
    localparam int WAITN = 2;
`else
    localparam int WAITN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start;
    logic [7:0]  pc_in;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] mbr_out;
    logic [7:0]  ir_opcode;
    logic [7:0]  ir_addr;
    logic        pc_inc;
    logic        fetch_done;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .pc_in(pc_in),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mbr_out(mbr_out), .ir_opcode(ir_opcode), .ir_addr(ir_addr), .pc_inc(pc_inc),
        .fetch_done(fetch_done), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Each cycle: inputs change 1ns after posedge, outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_start = 1'b0; pc_in = 8'h00; mem_ack = 1'b0; mem_rdata = 16'h0000;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); mid();
            checks++;
            if ({mem_req, busy, fetch_done, pc_inc, fetch_err} !== 5'b0) begin
                failures++;
                $display("FAIL reset_strobes cyc=%0d got=%b exp=00000", i,
                         {mem_req, busy, fetch_done, pc_inc, fetch_err});
            end
            checks++;
            if ({mem_addr, mbr_out} !== 24'h0) begin
                failures++;
                $display("FAIL reset_regs cyc=%0d addr=%h mbr=%h exp=0", i, mem_addr, mbr_out);
            end
        end
    endtask

    task automatic test_basic();
        tick(); pc_in = 8'h12; fetch_start = 1'b1; mid();
        tick(); fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hA53C; mid();
        checks++;
        if ({mem_req, busy, fetch_done, mem_addr} !== {1'b1, 1'b1, 1'b0, 8'h12}) begin
            failures++;
            $display("FAIL basic_req req=%b busy=%b done=%b addr=%h exp 1 1 0 12",
                     mem_req, busy, fetch_done, mem_addr);
        end
        tick(); mem_ack = 1'b0; mid();
        checks++;
        if ({fetch_done, pc_inc, mem_req, fetch_err} !== 4'b1100) begin
            failures++;
            $display("FAIL basic_done done/inc/req/err=%b exp=1100",
                     {fetch_done, pc_inc, mem_req, fetch_err});
        end
        checks++;
        if ({mbr_out, ir_opcode, ir_addr} !== {16'hA53C, 8'hA5, 8'h3C}) begin
            failures++;
            $display("FAIL basic_data mbr=%h op=%h ad=%h exp A53C A5 3C", mbr_out, ir_opcode, ir_addr);
        end
        tick(); mid();
        checks++;
        if ({fetch_done, pc_inc, busy} !== 3'b000) begin
            failures++;
            $display("FAIL basic_after done/inc/busy=%b exp=000", {fetch_done, pc_inc, busy});
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        tick(); pc_in = 8'h40; fetch_start = 1'b1; mid();
        for (int i = 1; i <= TO; i++) begin
            tick(); fetch_start = 1'b0; mid();
            checks++;
            if ({mem_req, fetch_err} !== 2'b10) begin
                failures++;
                $display("FAIL tmo_wait cyc=%0d req/err=%b exp=10", i, {mem_req, fetch_err});
            end
        end
        tick(); mid();
        checks++;
        if ({fetch_err, pc_inc, fetch_done, mem_req, busy} !== 5'b10001) begin
            failures++;
            $display("FAIL tmo_err err/inc/done/req/busy=%b exp=10001",
                     {fetch_err, pc_inc, fetch_done, mem_req, busy});
        end
        checks++;
        if (mbr_out !== 16'hA53C) begin
            failures++;
            $display("FAIL tmo_mbr got=%h exp=A53C", mbr_out);
        end
        tick(); mid();
        checks++;
        if ({fetch_err, busy} !== 2'b00) begin
            failures++;
            $display("FAIL tmo_after err/busy=%b exp=00", {fetch_err, busy});
        end
    endtask
`else
    task automatic test_long_wait();
        int err_seen;
        int req_low;
        err_seen = 0; req_low = 0;
        tick(); pc_in = 8'h30; fetch_start = 1'b1; mid();
        for (int i = 0; i < 300; i++) begin
            tick(); fetch_start = 1'b0; mid();
            if (fetch_err) err_seen++;
            if (!mem_req) req_low++;
        end
        checks++;
        if (err_seen !== 0 || req_low !== 0) begin
            failures++;
            $display("FAIL long_wait err_cycles=%0d req_low_cycles=%0d exp 0 0", err_seen, req_low);
        end
        tick(); mem_ack = 1'b1; mem_rdata = 16'h1234; mid();
        tick(); mem_ack = 1'b0; mid();
        checks++;
        if ({fetch_done, fetch_err, mbr_out} !== {1'b1, 1'b0, 16'h1234}) begin
            failures++;
            $display("FAIL long_done done=%b err=%b mbr=%h exp 1 0 1234", fetch_done, fetch_err, mbr_out);
        end
        tick(); mid();
    endtask
`endif

    task automatic test_wait_stable();
        int dones;
        dones = 0;
        tick(); pc_in = 8'h12; fetch_start = 1'b1; mid();
        for (int i = 1; i <= WAITN; i++) begin
            tick(); pc_in = 8'h77; mid();
            if (fetch_done) dones++;
            checks++;
            if ({mem_req, mem_addr} !== {1'b1, 8'h12}) begin
                failures++;
                $display("FAIL wait_addr cyc=%0d req=%b addr=%h exp 1 12", i, mem_req, mem_addr);
            end
        end
        tick(); mem_ack = 1'b1; mem_rdata = 16'h5A5A; mid();
        if (fetch_done) dones++;
        tick(); mem_ack = 1'b0; mid();
        if (fetch_done) dones++;
        checks++;
        if (mbr_out !== 16'h5A5A) begin
            failures++;
            $display("FAIL wait_mbr got=%h exp=5A5A", mbr_out);
        end
        tick(); fetch_start = 1'b0; mid();
        if (fetch_done) dones++;
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            failures++;
            $display("FAIL wait_no_rereq req/busy=%b exp=00", {mem_req, busy});
        end
        tick(); mid();
        if (fetch_done) dones++;
        checks++;
        if (dones !== 1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wait_single dones=%0d req=%b exp 1 0", dones, mem_req);
        end
    endtask

    task automatic test_stray_ack();
        tick(); mem_ack = 1'b1; mem_rdata = 16'hFFFF; mid();
        tick(); mid();
        checks++;
        if ({mbr_out, busy} !== {16'h5A5A, 1'b0}) begin
            failures++;
            $display("FAIL stray_ack mbr=%h busy=%b exp 5A5A 0", mbr_out, busy);
        end
        tick(); mem_ack = 1'b0; mid();
    endtask

    task automatic test_back_to_back();
        tick(); pc_in = 8'h11; fetch_start = 1'b1; mid();
        tick(); fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111; mid();
        tick(); mem_ack = 1'b0; pc_in = 8'h22; fetch_start = 1'b1; mid();
        checks++;
        if ({fetch_done, mbr_out} !== {1'b1, 16'h1111}) begin
            failures++;
            $display("FAIL b2b_first done=%b mbr=%h exp 1 1111", fetch_done, mbr_out);
        end
        tick(); mid();
        checks++;
        if ({busy, fetch_done} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_idle busy/done=%b exp=00", {busy, fetch_done});
        end
        tick(); fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h2222; mid();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h22}) begin
            failures++;
            $display("FAIL b2b_req req=%b addr=%h exp 1 22", mem_req, mem_addr);
        end
        tick(); mem_ack = 1'b0; mid();
        checks++;
        if ({fetch_done, pc_inc, mbr_out} !== {2'b11, 16'h2222}) begin
            failures++;
            $display("FAIL b2b_second done=%b inc=%b mbr=%h exp 1 1 2222", fetch_done, pc_inc, mbr_out);
        end
        tick(); mid();
    endtask

    task automatic test_reset_mid();
        tick(); pc_in = 8'h55; fetch_start = 1'b1; mid();
        tick(); fetch_start = 1'b0; mid();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre req=%b exp=1", mem_req);
        end
        tick(); rst_n = 1'b0; #1;
        checks++;
        if ({mem_req, busy, fetch_done, pc_inc, fetch_err, mbr_out, mem_addr} !== 29'h0) begin
            failures++;
            $display("FAIL rstmid_async req=%b busy=%b done=%b inc=%b err=%b mbr=%h addr=%h exp all 0",
                     mem_req, busy, fetch_done, pc_inc, fetch_err, mbr_out, mem_addr);
        end
        tick(); rst_n = 1'b1; mid();
        tick(); mid();
        checks++;
        if ({mem_req, busy, fetch_done, pc_inc, fetch_err} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_quiet strobes=%b exp=00000",
                     {mem_req, busy, fetch_done, pc_inc, fetch_err});
        end
        tick(); pc_in = 8'h01; fetch_start = 1'b1; mid();
        tick(); fetch_start = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF; mid();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin
            failures++;
            $display("FAIL rstmid_req req=%b addr=%h exp 1 01", mem_req, mem_addr);
        end
        tick(); mem_ack = 1'b0; mid();
        checks++;
        if ({fetch_done, pc_inc, mbr_out} !== {2'b11, 16'hBEEF}) begin
            failures++;
            $display("FAIL rstmid_done done=%b inc=%b mbr=%h exp 1 1 BEEF", fetch_done, pc_inc, mbr_out);
        end
        tick(); mid();
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_wait_stable();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
